// File: rtl/mem_host_bridge.sv
// Host/debug burst port sharing a PicoRV32-style memory bus with the CPU, one transaction at a time.
// Latency: CPU path adds one arbitration cycle; host bursts take >= 3 cycles per word plus memory wait.
// Backpressure: host cmd/wr/rd use valid/ready; a CPU request waiting behind a host burst is stalled via cpu_mem_ready.
module mem_host_bridge #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int LEN_WIDTH  = 9,
    parameter  int TIMEOUT    = 64,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cpu_mem_valid,
    input  logic                  cpu_mem_instr,
    output logic                  cpu_mem_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
    input  logic [DATA_WIDTH-1:0] cpu_mem_wdata,
    input  logic [STRB_WIDTH-1:0] cpu_mem_wstrb,
    output logic [DATA_WIDTH-1:0] cpu_mem_rdata,

    output logic                  mem_valid,
    output logic                  mem_instr,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [STRB_WIDTH-1:0] cmd_strb,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  hold_cpu,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU,
        S_HOST_START,
        S_HOST_WDATA,
        S_HOST_ACC,
        S_HOST_RD,
        S_HOST_NEXT
    } state_t;

    state_t                state;
    logic                  h_valid;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0] h_wdata;
    logic [STRB_WIDTH-1:0] h_wstrb;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remain;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  write_q;
    logic [TW-1:0]         tmo;

    logic                  in_cpu;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign in_cpu   = (state == S_CPU);
    assign addr_inc = cur_addr + ADDR_WIDTH'(STRB_WIDTH);

    // The CPU owns the downstream bus only while in S_CPU; otherwise the host registers drive it (all zero outside S_HOST_ACC).
    assign mem_valid     = in_cpu ? cpu_mem_valid : h_valid;
    assign mem_instr     = in_cpu & cpu_mem_instr;
    assign mem_addr      = in_cpu ? cpu_mem_addr  : h_addr;
    assign mem_wdata     = in_cpu ? cpu_mem_wdata : h_wdata;
    assign mem_wstrb     = in_cpu ? cpu_mem_wstrb : h_wstrb;
    assign cpu_mem_ready = in_cpu & mem_ready;
    assign cpu_mem_rdata = in_cpu ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_reset_n <= 1'b0;
            h_valid     <= 1'b0;
            h_addr      <= '0;
            h_wdata     <= '0;
            h_wstrb     <= '0;
            cur_addr    <= '0;
            remain      <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            tmo         <= '0;
        end else begin
            done        <= 1'b0;
            // Release lags the end of a held burst by one cycle; the assert edge is handled at command accept.
            cpu_reset_n <= !(hold_cpu && busy);

            unique case (state)
                S_IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        state       <= S_HOST_START;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        cur_addr    <= cmd_addr;
                        remain      <= cmd_len;
                        strb_q      <= cmd_strb;
                        write_q     <= cmd_write;
                        cpu_reset_n <= !hold_cpu;
                    end else if (cmd_ready && cpu_mem_valid) begin
                        state     <= S_CPU;
                        cmd_ready <= 1'b0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                S_CPU: begin
                    if (mem_ready) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end

                S_HOST_START: begin
                    if (remain == '0) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else if (write_q) begin
                        state    <= S_HOST_WDATA;
                        wr_ready <= 1'b1;
                    end else begin
                        state   <= S_HOST_ACC;
                        h_valid <= 1'b1;
                        h_addr  <= cur_addr;
                        tmo     <= '0;
                    end
                end

                S_HOST_WDATA: begin
                    if (wr_valid) begin
                        state    <= S_HOST_ACC;
                        wr_ready <= 1'b0;
                        h_valid  <= 1'b1;
                        h_addr   <= cur_addr;
                        h_wstrb  <= strb_q;
                        h_wdata  <= wr_data;
                        tmo      <= '0;
                    end
                end

                S_HOST_ACC: begin
                    if (mem_ready) begin
                        h_valid <= 1'b0;
                        h_addr  <= '0;
                        h_wstrb <= '0;
                        h_wdata <= '0;
                        if (write_q) begin
                            state <= S_HOST_NEXT;
                        end else begin
                            state    <= S_HOST_RD;
                            rd_data  <= mem_rdata;
                            rd_valid <= 1'b1;
                        end
                    end else if (TIMEOUT != 0 && tmo == TMO_LAST) begin
                        // Abort: the remainder of the burst is dropped.
                        state     <= S_IDLE;
                        h_valid   <= 1'b0;
                        h_addr    <= '0;
                        h_wstrb   <= '0;
                        h_wdata   <= '0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                S_HOST_RD: begin
                    if (rd_ready) begin
                        state    <= S_HOST_NEXT;
                        rd_valid <= 1'b0;
                    end
                end

                S_HOST_NEXT: begin
                    cur_addr <= addr_inc;
                    remain   <= remain - LEN_WIDTH'(1);
                    if (remain == LEN_WIDTH'(1)) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else if (write_q) begin
                        state    <= S_HOST_WDATA;
                        wr_ready <= 1'b1;
                    end else begin
                        state   <= S_HOST_ACC;
                        h_valid <= 1'b1;
                        h_addr  <= addr_inc;
                        tmo     <= '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_host_bridge.sv
// Directed bench: behavioural 1-cycle BRAM, a tiny RV32I-subset CPU model and host burst tasks around mem_host_bridge.
module tb_mem_host_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mem_valid, cpu_mem_instr, cpu_mem_ready;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic [3:0]  cmd_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        hold_cpu, cpu_reset_n, busy, done, err;

    mem_host_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(9), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_rdata(cpu_mem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_strb(cmd_strb),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .hold_cpu(hold_cpu), .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: 256 words indexed by addr[9:2], ready one cycle after a request is seen.
    logic [31:0] mem [256];
    logic [31:0] acc_log [512];
    int          acc_cnt = 0;
    logic        mem_dead = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_valid && !mem_ready && !mem_dead) begin
            mem_ready <= 1'b1;
            mem_rdata <= mem[mem_addr[9:2]];
            if (mem_wstrb != 4'h0) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_wstrb);
            acc_log[acc_cnt % 512] <= mem_addr;
            acc_cnt <= acc_cnt + 1;
        end else begin
            mem_ready <= 1'b0;
        end
    end

    int done_cnt = 0, mv_cnt = 0, hold_viol = 0, cpu_rdy_busy = 0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_valid) mv_cnt <= mv_cnt + 1;
        if (busy && hold_cpu && cpu_reset_n) hold_viol <= hold_viol + 1;
        if (busy && cpu_mem_ready) cpu_rdy_busy <= cpu_rdy_busy + 1;
    end

    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [8:0] l, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_strb = s;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_accept", 64'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_words(input int len);
        for (int i = 0; i < len; i++) begin
            int n = 0;
            wr_valid = 1'b1; wr_data = wbuf[i];
            while (!wr_ready && n < 100) begin @(negedge clk); n++; end
            chk("wr_ready", 64'(wr_ready), 1);
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic pull_words(input int len, input int stall_i, input int stall_n);
        for (int i = 0; i < len; i++) begin
            int n = 0;
            while (!rd_valid && n < 100) begin @(negedge clk); n++; end
            chk("rd_valid", 64'(rd_valid), 1);
            if (i == stall_i) begin
                logic [31:0] held = rd_data;
                logic        stable = 1'b1;
                repeat (stall_n) begin
                    @(negedge clk);
                    if (rd_data !== held || !rd_valid) stable = 1'b0;
                end
                chk("rd_hold", 64'(stable), 1);
            end
            rbuf[i] = rd_data;
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        chk("done", 64'(done), 1);
        @(negedge clk);
    endtask

    task automatic host_write(input logic [31:0] a, input int len, input logic [3:0] s);
        send_cmd(1'b1, a, 9'(len), s);
        push_words(len);
        wait_done();
    endtask

    task automatic host_read(input logic [31:0] a, input int len, input int stall_i, input int stall_n);
        send_cmd(1'b0, a, 9'(len), 4'h0);
        pull_words(len, stall_i, stall_n);
        wait_done();
    endtask

    task automatic cpu_xfer(input logic ins, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] ws, output logic [31:0] rd);
        int n = 0;
        cpu_mem_valid = 1'b1; cpu_mem_instr = ins; cpu_mem_addr = a; cpu_mem_wdata = wd; cpu_mem_wstrb = ws;
        while (!cpu_mem_ready && n < 200) begin @(negedge clk); n++; end
        chk("cpu_ready", 64'(cpu_mem_ready), 1);
        rd = cpu_mem_rdata;
        @(negedge clk);
        cpu_mem_valid = 1'b0; cpu_mem_instr = 1'b0; cpu_mem_wstrb = 4'h0;
    endtask

    logic [31:0] xr [32];
    logic [31:0] pc;
    int          bad_op = 0;

    task automatic run_cpu(input int n_instr);
        logic [31:0] ins, tmp, simm_i, simm_s, simm_j;
        pc = 32'h0;
        for (int r = 0; r < 32; r++) xr[r] = 32'h0;
        for (int k = 0; k < n_instr; k++) begin
            cpu_xfer(1'b1, pc, 32'h0, 4'h0, ins);
            simm_i = {{20{ins[31]}}, ins[31:20]};
            simm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            simm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            case (ins[6:0])
                7'h13: begin xr[ins[11:7]] = xr[ins[19:15]] + simm_i; pc = pc + 4; end
                7'h33: begin xr[ins[11:7]] = xr[ins[19:15]] + xr[ins[24:20]]; pc = pc + 4; end
                7'h23: begin cpu_xfer(1'b0, xr[ins[19:15]] + simm_s, xr[ins[24:20]], 4'hF, tmp); pc = pc + 4; end
                7'h6F: begin xr[ins[11:7]] = pc + 4; pc = pc + simm_j; end
                default: bad_op++;
            endcase
            xr[0] = 32'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    int          base, d0, m0, c0;
    logic [31:0] crd;

    initial begin
        cpu_mem_valid = 0; cpu_mem_instr = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0; cpu_mem_wstrb = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_strb = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 0; hold_cpu = 1;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;

        // Reset state and release of the CPU reset
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({cpu_mem_ready, mem_valid, mem_instr, cmd_ready, wr_ready, rd_valid,
                            cpu_reset_n, busy, done, err}), 0);
        chk("rst_dat", 64'(|{cpu_mem_rdata, mem_addr, mem_wdata, mem_wstrb, rd_data}), 0);
        reset_n = 1'b1;
        chk("cpu_rst_low", 64'(cpu_reset_n), 0);
        @(negedge clk);
        chk("cpu_rst_rel", 64'(cpu_reset_n), 1);
        chk("idle_ready", 64'(cmd_ready), 1);

        // Program load with the CPU held, then let the CPU run it
        wbuf[0] = 32'h00A00093; wbuf[1] = 32'h00108133; wbuf[2] = 32'h002081B3;
        wbuf[3] = 32'h08302023; wbuf[4] = 32'hFF1FF06F;
        send_cmd(1'b1, 32'h0, 9'd5, 4'hF);
        chk("busy", 64'(busy), 1);
        chk("cpu_held", 64'(cpu_reset_n), 0);
        push_words(5);
        wait_done();
        chk("hold_viol", 64'(hold_viol), 0);
        chk("cpu_released", 64'(cpu_reset_n), 1);
        base = acc_cnt;
        run_cpu(5);
        chk("cpu_ops", 64'(bad_op), 0);
        chk("cpu_pc", 64'(pc), 'h0);
        chk("cpu_x3", 64'(xr[3]), 30);
        chk("sw_addr", 64'(acc_log[(base + 4) % 512]), 'h80);
        host_read(32'h80, 1, -1, 0);
        chk("rd_30", 64'(rbuf[0]), 30);

        // Burst crossing the top of the address space
        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        base = acc_cnt;
        host_write(32'hFFFFFFF8, 4, 4'hF);
        chk("wrap_a0", 64'(acc_log[(base + 0) % 512]), 'hFFFFFFF8);
        chk("wrap_a1", 64'(acc_log[(base + 1) % 512]), 'hFFFFFFFC);
        chk("wrap_a2", 64'(acc_log[(base + 2) % 512]), 'h0);
        chk("wrap_a3", 64'(acc_log[(base + 3) % 512]), 'h4);
        host_read(32'hFFFFFFF8, 4, -1, 0);
        chk("wrap_d0", 64'(rbuf[0]), 'h11111111);
        chk("wrap_d1", 64'(rbuf[1]), 'h22222222);
        chk("wrap_d2", 64'(rbuf[2]), 'h33333333);
        chk("wrap_d3", 64'(rbuf[3]), 'h44444444);

        // Read burst with rd_ready stalled on the second word
        base = acc_cnt; d0 = done_cnt;
        host_read(32'h0, 3, 1, 5);
        repeat (2) @(negedge clk);
        chk("stall_acc", 64'(acc_cnt - base), 3);
        chk("stall_done", 64'(done_cnt - d0), 1);
        chk("stall_d0", 64'(rbuf[0]), 'h33333333);
        chk("stall_d1", 64'(rbuf[1]), 'h44444444);
        chk("stall_d2", 64'(rbuf[2]), 'h002081B3);

        // Same-cycle host command and CPU request: host first
        hold_cpu = 1'b0;
        wbuf[0] = 32'hA5A5A5A5; wbuf[1] = 32'h5A5A5A5A;
        base = acc_cnt; c0 = cpu_rdy_busy;
        fork
            host_write(32'h40, 2, 4'hF);
            cpu_xfer(1'b0, 32'h80, 32'h0, 4'h0, crd);
        join
        chk("tie_cpu_rd", 64'(crd), 30);
        chk("tie_a0", 64'(acc_log[(base + 0) % 512]), 'h40);
        chk("tie_a1", 64'(acc_log[(base + 1) % 512]), 'h44);
        chk("tie_a2", 64'(acc_log[(base + 2) % 512]), 'h80);
        chk("tie_stall", 64'(cpu_rdy_busy - c0), 0);
        chk("tie_cpu_run", 64'(cpu_reset_n), 1);

        // Partial strobes on a write word
        wbuf[0] = 32'hFFFFFFFF;
        host_write(32'h44, 1, 4'b0011);
        host_read(32'h40, 2, -1, 0);
        chk("strb_d0", 64'(rbuf[0]), 'hA5A5A5A5);
        chk("strb_d1", 64'(rbuf[1]), 'h5A5AFFFF);
        hold_cpu = 1'b1;

        // Memory never answers: timeout aborts the burst
        mem_dead = 1'b1;
        m0 = mv_cnt; d0 = done_cnt;
        send_cmd(1'b0, 32'h100, 9'd2, 4'h0);
        wait_done();
        repeat (2) @(negedge clk);
        chk("tmo_mv_cycles", 64'(mv_cnt - m0), 8);
        chk("tmo_err", 64'(err), 1);
        chk("tmo_done", 64'(done_cnt - d0), 1);
        chk("tmo_idle", 64'(cmd_ready), 1);
        mem_dead = 1'b0;

        // Zero-length command: clears err, done next cycle, no memory access
        m0 = mv_cnt; d0 = done_cnt;
        send_cmd(1'b1, 32'h200, 9'd0, 4'hF);
        chk("len0_err_clr", 64'(err), 0);
        chk("len0_done_early", 64'(done), 0);
        @(negedge clk);
        chk("len0_done", 64'(done), 1);
        repeat (3) @(negedge clk);
        chk("len0_mv", 64'(mv_cnt - m0), 0);
        chk("len0_done_cnt", 64'(done_cnt - d0), 1);

        // Reset in the middle of a burst
        d0 = done_cnt;
        send_cmd(1'b1, 32'h300, 9'd2, 4'hF);
        reset_n = 1'b0;
        #1;
        chk("midrst_ctl", 64'({busy, done, cmd_ready, wr_ready, mem_valid, cpu_reset_n}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_done", 64'(done_cnt - d0), 0);
        chk("midrst_idle", 64'(cmd_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_host_bridge.md
Name: mem_host_bridge

Overview:
- Sits between cpu and bram_controller on the PicoRV32 native memory interface.
- Gives a host/debug port burst read and write access to memory, so programs can be loaded and results read back without testbench-side muxing.
- Arbitrates per transaction between the CPU and the host.
- Optionally holds the CPU in reset while a host session is active.

Parameters:
- ADDR_WIDTH, 32, byte-address width of all address ports.
- DATA_WIDTH, 32, word width; must be a multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
- LEN_WIDTH, 9, width of the burst-length field; maximum burst is 2^LEN_WIDTH-1 words.
- TIMEOUT, 64, cycles to wait for mem_ready before a host access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cpu_mem_valid  in  1  CPU request
- cpu_mem_instr  in  1  CPU fetch flag
- cpu_mem_ready  out  1  CPU completion
- cpu_mem_addr  in  ADDR_WIDTH  CPU address
- cpu_mem_wdata  in  DATA_WIDTH  CPU write data
- cpu_mem_wstrb  in  STRB_WIDTH  CPU byte strobes; 0 means read
- cpu_mem_rdata  out  DATA_WIDTH  CPU read data
- mem_valid  out  1  downstream request
- mem_instr  out  1  downstream fetch flag
- mem_ready  in  1  downstream completion
- mem_addr  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_wstrb  out  STRB_WIDTH  downstream strobes
- mem_rdata  in  DATA_WIDTH  downstream read data
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  host command accepted
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  burst start byte address; must be word-aligned
- cmd_len  in  LEN_WIDTH  number of words in the burst
- cmd_strb  in  STRB_WIDTH  byte strobes applied to every write word
- wr_valid  in  1  host write-data valid
- wr_ready  out  1  host write-data accepted
- wr_data  in  DATA_WIDTH  host write data
- rd_valid  out  1  host read-data valid
- rd_ready  in  1  host read-data accepted
- rd_data  out  DATA_WIDTH  host read data
- hold_cpu  in  1  when 1, the CPU is held in reset for the duration of any host burst
- cpu_reset_n  out  1  reset output to the CPU
- busy  out  1  host burst in progress
- done  out  1  one-cycle pulse at burst end
- err  out  1  sticky timeout flag; cleared when the next command is accepted

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE.
  - mem_valid, cmd_ready, wr_ready, rd_valid, busy, done, err = 0.
  - cpu_mem_ready = 0.
  - cpu_reset_n = 0.
- cpu_reset_n = reset_n AND NOT (hold_cpu AND busy).
  - Driven from a register; it deasserts one cycle after both reset_n rises and any held burst ends.
- States and transitions:
  - IDLE: cmd_ready = 1.
    - If cmd_valid: latch cmd into registers, go to HOST_START.
    - Else if cpu_mem_valid: go to CPU.
    - Host wins a same-cycle tie.
  - CPU: downstream mem_* is driven combinationally from cpu_mem_*; cpu_mem_ready = mem_ready; cpu_mem_rdata = mem_rdata.
    - On mem_ready, return to IDLE.
    - A CPU transaction is never interrupted.
  - HOST_START: busy = 1.
    - If len = 0: pulse done, return to IDLE; no memory access is made.
    - Else: go to HOST_WDATA for writes, HOST_ACC for reads.
  - HOST_WDATA: wr_ready = 1. On wr_valid, capture wr_data and go to HOST_ACC.
  - HOST_ACC: mem_valid = 1, mem_instr = 0, mem_addr = current address.
    - Writes: mem_wstrb = cmd_strb. Reads: mem_wstrb = 0.
    - mem_valid is held until mem_ready is sampled high and deasserts the next cycle.
    - Reads: capture mem_rdata into rd_data and go to HOST_RD.
    - Writes: go to HOST_NEXT.
  - HOST_RD: rd_valid = 1; rd_data is held stable until rd_ready.
    - On rd_ready, go to HOST_NEXT.
  - HOST_NEXT:
    - Address += STRB_WIDTH; wraps modulo 2^ADDR_WIDTH.
    - Remaining count -= 1.
    - If remaining = 0: pulse done, go to IDLE.
    - Else: go to HOST_WDATA or HOST_ACC.
- Outside state CPU:
  - cpu_mem_ready = 0; a pending CPU request stalls and is served after the burst.
  - cpu_mem_rdata = 0.
- Timeout:
  - Counts cycles in HOST_ACC.
  - Reaching TIMEOUT without mem_ready: drop mem_valid, set err, pulse done, go to IDLE. The rest of the burst is discarded.
- Host-side handshakes use the valid/ready rule: a transfer occurs on the cycle both are high.
- Downstream mem_* outputs are 0 in every state except CPU and HOST_ACC.
- Reset mid-burst: everything returns to reset values immediately; no partial done pulse.
- Throughput: minimum 3 cycles per host word plus memory latency. No pipelining.

Test Plan:
- Reset held, then released:
  - All outputs are 0 during reset.
  - cpu_reset_n rises 1 cycle after reset_n rises.
- Host write of 5 words to 0x00 with hold_cpu = 1 (addi x1,x0,10; add x2,x1,x1; add x3,x1,x2; sw x3,0x80(x0); jal x0,-16), then release:
  - cpu_reset_n is low throughout the burst.
  - The CPU then runs.
  - A host read of 0x80 with len = 1 returns 30.
- Write and read across the top of the address space: write len = 4 at 0xFFFFFFF8, then read len = 4 at 0xFFFFFFF8:
  - Accesses land at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - Read data matches the written data.
- Read burst len = 3 with rd_ready held low for 5 cycles on the second word:
  - rd_data is held stable during the stall.
  - No extra memory access is issued.
  - done pulses once.
- cmd_valid and cpu_mem_valid rise in the same cycle while hold_cpu = 0:
  - The host burst is served first.
  - cpu_mem_ready stays 0 until the burst ends.
  - The CPU access completes afterwards.
- mem_ready tied low, TIMEOUT = 8:
  - mem_valid drops after 8 cycles.
  - err = 1 and done pulses.
  - The next accepted command clears err.
- len = 0 command:
  - done pulses 1 cycle after acceptance.
  - mem_valid is never asserted.
